// File: rtl/party_video_timing_pkg.sv
// Shared timing types, 480x272 LCD defaults and the width helper for the
// party video timing generator.
package party_video_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } axis_timing_t;

  localparam axis_timing_t LCD_H_TIMING = '{active: 32'd480, fp: 32'd2, sync: 32'd41, bp: 32'd2};
  localparam axis_timing_t LCD_V_TIMING = '{active: 32'd272, fp: 32'd2, sync: 32'd10, bp: 32'd2};
  localparam int unsigned  LCD_CE_DIV     = 32'd4;
  localparam int unsigned  LCD_NUM_FRAMES = 32'd10;
  localparam int unsigned  LCD_FRAME_HOLD = 32'd4;

  function automatic int unsigned axis_total(input axis_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/party_video_timing_if.sv
// Control inputs and video outputs of the timing generator, bundled for the
// sprite/palette fetch path.
interface party_video_timing_if #(
  parameter int unsigned XW = 32'd10,
  parameter int unsigned YW = 32'd9,
  parameter int unsigned AW = 32'd4
) ();
  logic          i_pause;
  logic          i_step;
  logic          i_turbo;
  logic          o_ce_pix;
  logic          o_hs;
  logic          o_vs;
  logic          o_de;
  logic [XW-1:0] o_x;
  logic [YW-1:0] o_y;
  logic          o_frame_start;
  logic [AW-1:0] o_anim_idx;

  modport master (
    input  i_pause, i_step, i_turbo,
    output o_ce_pix, o_hs, o_vs, o_de, o_x, o_y, o_frame_start, o_anim_idx
  );

  modport slave (
    output i_pause, i_step, i_turbo,
    input  o_ce_pix, o_hs, o_vs, o_de, o_x, o_y, o_frame_start, o_anim_idx
  );
endinterface

// File: rtl/party_anim_seq.sv
// Animation-frame sequencer: hold counter, step edge detect and frame index.
// frame_evt fires on the pixel that wraps the counters into pixel (0,0).
module party_anim_seq
  import party_video_pkg::*;
#(
  parameter int unsigned NUM_FRAMES = LCD_NUM_FRAMES,
  parameter int unsigned FRAME_HOLD = LCD_FRAME_HOLD,
  parameter int unsigned AW         = width_of(NUM_FRAMES)
) (
  input  logic          clk36m,
  input  logic          i_res_n,
  input  logic          frame_evt,
  input  logic          pause,
  input  logic          step,
  input  logic          turbo,
  output logic [AW-1:0] anim_idx
);
  localparam int unsigned HW         = width_of(FRAME_HOLD);
  localparam int unsigned THR_TURBO  = (FRAME_HOLD / 32'd2 >= 32'd1) ? FRAME_HOLD / 32'd2 : 32'd1;
  localparam logic [HW-1:0] LIM_NORM  = HW'(FRAME_HOLD - 32'd1);
  localparam logic [HW-1:0] LIM_TURBO = HW'(THR_TURBO - 32'd1);
  localparam logic [AW-1:0] ANIM_LAST = AW'(NUM_FRAMES - 32'd1);

  logic [HW-1:0] hold_r, hold_nxt_s, lim_s;
  logic [AW-1:0] anim_r, anim_nxt_s;
  logic          step_d_r, pause_d_r, step_req_r, step_req_nxt_s, adv_s;

  // Next-state for hold, index and pending step request.
  always_comb begin
    hold_nxt_s     = hold_r;
    anim_nxt_s     = anim_r;
    step_req_nxt_s = step_req_r;
    adv_s          = 1'b0;
    lim_s          = turbo ? LIM_TURBO : LIM_NORM;
    if (frame_evt && !pause) begin
      if (hold_r >= lim_s) begin
        hold_nxt_s = '0;
        adv_s      = 1'b1;
      end else begin
        hold_nxt_s = hold_r + HW'(1);
      end
    end else if (frame_evt && step_req_r) begin
      adv_s = 1'b1;
    end else begin
      adv_s = 1'b0;
    end
    if (adv_s) begin
      anim_nxt_s = (anim_r == ANIM_LAST) ? '0 : anim_r + AW'(1);
    end else begin
      anim_nxt_s = anim_r;
    end
    // A pending step dies with the pause; a fresh edge outranks consumption.
    if (pause_d_r && !pause) begin
      step_req_nxt_s = 1'b0;
    end else if (pause && step && !step_d_r) begin
      step_req_nxt_s = 1'b1;
    end else if (frame_evt && pause) begin
      step_req_nxt_s = 1'b0;
    end else begin
      step_req_nxt_s = step_req_r;
    end
  end

  // Sequencer state and input history registers.
  always_ff @(posedge clk36m or negedge i_res_n) begin
    if (!i_res_n) begin
      hold_r     <= '0;
      anim_r     <= '0;
      step_d_r   <= 1'b0;
      pause_d_r  <= 1'b0;
      step_req_r <= 1'b0;
    end else begin
      hold_r     <= hold_nxt_s;
      anim_r     <= anim_nxt_s;
      step_d_r   <= step;
      pause_d_r  <= pause;
      step_req_r <= step_req_nxt_s;
    end
  end

  assign anim_idx = anim_r;
endmodule

// File: rtl/party_video_timing.sv
// Parametrised LCD timing generator: pixel enable divider, h/v counters,
// registered sync/DE/position outputs and the animation sequencer.
module party_video_timing
  import party_video_pkg::*;
#(
  parameter int unsigned CE_DIV     = LCD_CE_DIV,
  parameter int unsigned H_ACTIVE   = LCD_H_TIMING.active,
  parameter int unsigned H_FP       = LCD_H_TIMING.fp,
  parameter int unsigned H_SYNC     = LCD_H_TIMING.sync,
  parameter int unsigned H_BP       = LCD_H_TIMING.bp,
  parameter int unsigned V_ACTIVE   = LCD_V_TIMING.active,
  parameter int unsigned V_FP       = LCD_V_TIMING.fp,
  parameter int unsigned V_SYNC     = LCD_V_TIMING.sync,
  parameter int unsigned V_BP       = LCD_V_TIMING.bp,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned NUM_FRAMES = LCD_NUM_FRAMES,
  parameter int unsigned FRAME_HOLD = LCD_FRAME_HOLD
) (
  input logic                  clk36m,
  input logic                  i_res_n,
  party_video_timing_if.master vif
);
  localparam axis_timing_t H_T = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam axis_timing_t V_T = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int unsigned H_TOTAL = axis_total(H_T);
  localparam int unsigned V_TOTAL = axis_total(V_T);
  localparam int unsigned XW = width_of(H_TOTAL);
  localparam int unsigned YW = width_of(V_TOTAL);
  localparam int unsigned DW = width_of(CE_DIV);
  localparam int unsigned AW = width_of(NUM_FRAMES);

  localparam logic [DW-1:0] DIV_LAST = DW'(CE_DIV - 32'd1);
  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 32'd1);
  localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC - 32'd1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 32'd1);
  localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG   = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC - 32'd1);

  logic [DW-1:0] div_r;
  logic [XW-1:0] hc_r;
  logic [YW-1:0] vc_r;
  logic [AW-1:0] anim_s;
  logic ce_s, hc_last_s, vc_last_s, de_s, hs_act_s, vs_act_s, fs_s, frame_evt_s;

  assign ce_s        = (div_r == DIV_LAST);
  assign hc_last_s   = (hc_r == H_LAST);
  assign vc_last_s   = (vc_r == V_LAST);
  assign de_s        = (hc_r < H_ACT) && (vc_r < V_ACT);
  assign hs_act_s    = (hc_r >= HS_BEG) && (hc_r <= HS_END);
  assign vs_act_s    = (vc_r >= VS_BEG) && (vc_r <= VS_END);
  assign fs_s        = (hc_r == '0) && (vc_r == '0);
  // Sequencer updates as counters enter (0,0) so its index lands with o_frame_start.
  assign frame_evt_s = ce_s && hc_last_s && vc_last_s;
  assign vif.o_ce_pix = ce_s;

  // Pixel divider and raster counters.
  always_ff @(posedge clk36m or negedge i_res_n) begin
    if (!i_res_n) begin
      div_r <= '0;
      hc_r  <= '0;
      vc_r  <= '0;
    end else if (ce_s) begin
      div_r <= '0;
      if (hc_last_s) begin
        hc_r <= '0;
        vc_r <= vc_last_s ? '0 : vc_r + YW'(1);
      end else begin
        hc_r <= hc_r + XW'(1);
      end
    end else begin
      div_r <= div_r + DW'(1);
    end
  end

  // Output register stage, one pixel behind the counters.
  always_ff @(posedge clk36m or negedge i_res_n) begin
    if (!i_res_n) begin
      vif.o_hs          <= ~HS_POL;
      vif.o_vs          <= ~VS_POL;
      vif.o_de          <= 1'b0;
      vif.o_x           <= '0;
      vif.o_y           <= '0;
      vif.o_frame_start <= 1'b0;
      vif.o_anim_idx    <= '0;
    end else if (ce_s) begin
      vif.o_hs          <= hs_act_s ? HS_POL : ~HS_POL;
      vif.o_vs          <= vs_act_s ? VS_POL : ~VS_POL;
      vif.o_de          <= de_s;
      vif.o_x           <= hc_r;
      vif.o_y           <= vc_r;
      vif.o_frame_start <= fs_s;
      vif.o_anim_idx    <= anim_s;
    end
  end

  party_anim_seq #(
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_HOLD (FRAME_HOLD),
    .AW         (AW)
  ) u_anim_seq (
    .clk36m    (clk36m),
    .i_res_n   (i_res_n),
    .frame_evt (frame_evt_s),
    .pause     (vif.i_pause),
    .step      (vif.i_step),
    .turbo     (vif.i_turbo),
    .anim_idx  (anim_s)
  );
endmodule

// File: tb/tb_party_video_timing.sv
// Scoreboard bench for party_video_timing on the small 8x6 raster, with an
// active-low and an active-high sync instance running side by side.
module tb_party_video_timing;
  localparam int CE_DIV = 2;
  localparam int H_TOT  = 8;
  localparam int V_TOT  = 6;
  localparam int NF     = 3;
  localparam int FH     = 2;

  typedef struct {
    int x; int y; int de; int hs_act; int vs_act; int fs; int anim;
  } exp_t;

  logic clk36m = 1'b0;
  logic rst_n  = 1'b0;
  logic tb_pause = 1'b0, tb_step = 1'b0, tb_turbo = 1'b0;

  party_video_timing_if #(.XW(3), .YW(3), .AW(2)) if0 ();
  party_video_timing_if #(.XW(3), .YW(3), .AW(2)) if1 ();

  assign if0.i_pause = tb_pause;
  assign if0.i_step  = tb_step;
  assign if0.i_turbo = tb_turbo;
  assign if1.i_pause = tb_pause;
  assign if1.i_step  = tb_step;
  assign if1.i_turbo = tb_turbo;

  party_video_timing #(
    .CE_DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .NUM_FRAMES(3), .FRAME_HOLD(2)
  ) dut0 (.clk36m(clk36m), .i_res_n(rst_n), .vif(if0.master));

  party_video_timing #(
    .CE_DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .NUM_FRAMES(3), .FRAME_HOLD(2)
  ) dut1 (.clk36m(clk36m), .i_res_n(rst_n), .vif(if1.master));

  always #5 clk36m = ~clk36m;

  int n_cmp = 0, n_err = 0;
  exp_t sb_q[$];
  int m_div, m_hc, m_vc, m_hold, m_anim, m_step_req, m_step_prev, m_pause_prev;
  int cyc_n = 0, last_fs_cyc = 0, fs_gap = 0, obs_anim = 0;
  int pop_valid = 0, pop_x = 0, pop_y = 0, fs_seen = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_div = 0; m_hc = 0; m_vc = 0; m_hold = 0; m_anim = 0;
    m_step_req = 0; m_step_prev = 0; m_pause_prev = 0;
  endtask

  task automatic reset_checks();
    check_eq("rst_ce",    int'(if0.o_ce_pix), 0);
    check_eq("rst_x",     int'(if0.o_x), 0);
    check_eq("rst_y",     int'(if0.o_y), 0);
    check_eq("rst_de",    int'(if0.o_de), 0);
    check_eq("rst_fs",    int'(if0.o_frame_start), 0);
    check_eq("rst_anim",  int'(if0.o_anim_idx), 0);
    check_eq("rst_hs_lo", int'(if0.o_hs), 1);
    check_eq("rst_vs_lo", int'(if0.o_vs), 1);
    check_eq("rst_hs_hi", int'(if1.o_hs), 0);
    check_eq("rst_vs_hi", int'(if1.o_vs), 0);
  endtask

  // One clk36m cycle: advance the reference model at the edge, check #1 later.
  task automatic cyc();
    exp_t e;
    int ce, evt, rise, adv, thr, pushed;
    ce = 0; pushed = 0; adv = 0;
    @(posedge clk36m);
    cyc_n++;
    if (rst_n) begin
      ce   = (m_div == CE_DIV - 1);
      rise = tb_step && !m_step_prev;
      evt  = ce && (m_hc == H_TOT - 1) && (m_vc == V_TOT - 1);
      thr  = tb_turbo ? ((FH / 2 > 0) ? FH / 2 : 1) : FH;
      if (ce) begin
        e.x = m_hc; e.y = m_vc;
        e.de = (m_hc < 4) && (m_vc < 3);
        e.hs_act = (m_hc >= 5) && (m_hc <= 6);
        e.vs_act = (m_vc == 4);
        e.fs = (m_hc == 0) && (m_vc == 0);
        e.anim = m_anim;
        sb_q.push_back(e);
        pushed = 1;
      end
      if (evt && !tb_pause) begin
        if (m_hold >= thr - 1) begin m_hold = 0; adv = 1; end
        else m_hold = m_hold + 1;
      end else if (evt && m_step_req) begin
        adv = 1; m_step_req = 0;
      end
      if (m_pause_prev && !tb_pause) m_step_req = 0;
      else if (tb_pause && rise) m_step_req = 1;
      if (adv) m_anim = (m_anim + 1) % NF;
      if (ce) begin
        m_div = 0;
        if (m_hc == H_TOT - 1) begin
          m_hc = 0;
          m_vc = (m_vc == V_TOT - 1) ? 0 : m_vc + 1;
        end else m_hc = m_hc + 1;
      end else m_div = m_div + 1;
      m_step_prev = tb_step;
      m_pause_prev = tb_pause;
    end else model_reset();
    #1;
    check_eq("ce_pix", int'(if0.o_ce_pix), int'(m_div == CE_DIV - 1));
    pop_valid = 0;
    if (pushed) begin
      if (sb_q.size() == 0) check_eq("sb_empty", 0, 1);
      else begin
        e = sb_q.pop_front();
        pop_valid = 1; pop_x = e.x; pop_y = e.y;
        check_eq("x",     int'(if0.o_x), e.x);
        check_eq("y",     int'(if0.o_y), e.y);
        check_eq("de",    int'(if0.o_de), e.de);
        check_eq("hs_lo", int'(if0.o_hs), e.hs_act ? 0 : 1);
        check_eq("vs_lo", int'(if0.o_vs), e.vs_act ? 0 : 1);
        check_eq("hs_hi", int'(if1.o_hs), e.hs_act);
        check_eq("vs_hi", int'(if1.o_vs), e.vs_act);
        check_eq("fs",    int'(if0.o_frame_start), e.fs);
        check_eq("anim",  int'(if0.o_anim_idx), e.anim);
        if (e.fs) begin
          fs_seen = 1;
          fs_gap = cyc_n - last_fs_cyc;
          last_fs_cyc = cyc_n;
          obs_anim = int'(if0.o_anim_idx);
        end
      end
    end
  endtask

  task automatic run_to_fs(output int anim, output int gap);
    int n;
    n = 0; fs_seen = 0;
    while (!fs_seen && n < 400) begin cyc(); n++; end
    if (!fs_seen) check_eq("fs_timeout", 0, 1);
    anim = obs_anim; gap = fs_gap;
  endtask

  initial begin
    int seq[20] = '{0,0,1,1,2,2,0,0,1,1,2,2, 2,0,0,1,2,0,0,1};
    int a, g, n, found;
    model_reset();
    repeat (3) cyc();
    reset_checks();
    rst_n = 1'b1;
    last_fs_cyc = cyc_n;

    // Free run, then pause/step, turbo on with hold pending, turbo off.
    for (int f = 0; f < 20; f++) begin
      run_to_fs(a, g);
      check_eq("anim_seq", a, seq[f]);
      check_eq(f == 0 ? "fs_first_lat" : "frame_period", g, f == 0 ? 2 : 96);
      if (f == 11) tb_pause = 1'b1;
      if (f == 12) begin
        for (int k = 0; k < 3; k++) begin
          tb_step = 1'b1; cyc();
          tb_step = 1'b0; cyc();
        end
      end
      if (f == 14) begin tb_pause = 1'b0; tb_turbo = 1'b1; end
      if (f == 15) begin tb_step = 1'b1; cyc(); tb_step = 1'b0; end
      if (f == 17) tb_turbo = 1'b0;
    end

    // Asynchronous reset mid-frame at pixel (2,1).
    n = 0; found = 0;
    while (!found && n < 200) begin
      cyc(); n++;
      if (pop_valid && pop_x == 2 && pop_y == 1) found = 1;
    end
    if (!found) check_eq("find_x2y1", 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks();
    model_reset();
    sb_q.delete();
    repeat (2) cyc();
    rst_n = 1'b1;
    last_fs_cyc = cyc_n;
    run_to_fs(a, g);
    check_eq("rel_fs_lat", g, 2);
    check_eq("rel_x", pop_x, 0);
    check_eq("rel_y", pop_y, 0);
    check_eq("rel_anim", a, 0);
    run_to_fs(a, g);
    check_eq("rel_anim2", a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
